ring_decode: RTL and testbench

One-hot ring decoder and checker: the receiving end of the team's 4-bit one-hot ring counter. It samples the rotating one-hot word and verifies the rotation sequence. Once the sequence is confirmed, it emits the binary index of the hot bit, a revolution marker and error indications. It sits downstream of any ring-counter phase generator and turns the phase into a binary slot number for consumers.

---
 rtl/ring_decode.sv | 120 ++++++++++++
 tb/tb_ring_decode.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ring_decode.sv
// One-hot ring decoder/checker: hunts for a one-hot word, confirms LOCK_CNT
// correct MSB->LSB rotations, then reports the hot-bit index and rotation errors.
module ring_decode #(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int ERR_W    = 8
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     ring_vld,
  input  logic                     err_clr,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     idx_vld,
  output logic                     wrap,
  output logic                     locked,
  output logic                     err_pulse,
  output logic [ERR_W-1:0]         err_cnt
);
  localparam int IW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_HUNT, S_CHECK, S_LOCK} state_t;

  state_t           state, state_d;
  logic [WIDTH-1:0] prev, prev_d;
  logic [3:0]       mcnt, mcnt_d;
  logic [IW-1:0]    idx_d, pos;
  logic             idx_vld_d, wrap_d, err_d;
  logic             one_hot;
  logic [WIDTH-1:0] expected;

  // x & (x-1) clears the lowest set bit; zero result means at most one bit set
  assign one_hot  = (ring_in != '0) && ((ring_in & (ring_in - WIDTH'(1))) == '0);
  assign expected = {prev[0], prev[WIDTH-1:1]};

  always_comb begin
    pos = '0;
    for (int i = 0; i < WIDTH; i++)
      if (ring_in[i]) pos = IW'(i);
  end

  always_comb begin
    state_d   = state;
    prev_d    = prev;
    mcnt_d    = mcnt;
    idx_d     = idx;
    idx_vld_d = 1'b0;
    wrap_d    = 1'b0;
    err_d     = 1'b0;
    if (ring_vld) begin
      unique case (state)
        S_HUNT: begin
          if (one_hot) begin
            prev_d  = ring_in;
            mcnt_d  = '0;
            state_d = S_CHECK;
          end
        end
        S_CHECK: begin
          if (!one_hot) begin
            state_d = S_HUNT;
          end else if (ring_in == expected) begin
            mcnt_d = mcnt + 4'd1;
            prev_d = ring_in;
            if (mcnt + 4'd1 == 4'(LOCK_CNT)) begin
              state_d   = S_LOCK;
              idx_d     = pos;
              idx_vld_d = 1'b1;
              wrap_d    = (pos == IW'(WIDTH-1));
            end
          end else begin
            prev_d = ring_in;
            mcnt_d = '0;
          end
        end
        S_LOCK: begin
          if (one_hot && ring_in == expected) begin
            prev_d    = ring_in;
            idx_d     = pos;
            idx_vld_d = 1'b1;
            wrap_d    = (pos == IW'(WIDTH-1));
          end else begin
            // the breaking sample is discarded; the next one-hot word restarts the hunt
            err_d   = 1'b1;
            state_d = S_HUNT;
          end
        end
        default: state_d = S_HUNT;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state     <= S_HUNT;
      prev      <= '0;
      mcnt      <= '0;
      idx       <= '0;
      idx_vld   <= 1'b0;
      wrap      <= 1'b0;
      locked    <= 1'b0;
      err_pulse <= 1'b0;
      err_cnt   <= '0;
    end else begin
      state     <= state_d;
      prev      <= prev_d;
      mcnt      <= mcnt_d;
      idx       <= idx_d;
      idx_vld   <= idx_vld_d;
      wrap      <= wrap_d;
      locked    <= (state_d == S_LOCK);
      err_pulse <= err_d;
      if (err_clr)
        err_cnt <= '0;
      else if (err_d && err_cnt != '1)
        err_cnt <= err_cnt + ERR_W'(1);
    end
  end

endmodule

// File: tb/tb_ring_decode.sv
// Self-checking bench for ring_decode: directed scenarios plus randomized
// traffic against a position-based reference model.
module tb_ring_decode;
  localparam int W = 4;
  localparam int LC = 2;

  logic clk = 1'b0;
  logic clr = 1'b0;
  logic [W-1:0] ring_in = '0;
  logic ring_vld = 1'b0;
  logic err_clr = 1'b0;
  logic [1:0] idx, idx2;
  logic idx_vld, wrap, locked, err_pulse;
  logic idx_vld2, wrap2, locked2, err_pulse2;
  logic [7:0] err_cnt;
  logic [1:0] err_cnt2;

  int checks = 0;
  int errors = 0;

  ring_decode #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(8)) u_dut (
    .clk(clk), .clr(clr), .ring_in(ring_in), .ring_vld(ring_vld), .err_clr(err_clr),
    .idx(idx), .idx_vld(idx_vld), .wrap(wrap), .locked(locked),
    .err_pulse(err_pulse), .err_cnt(err_cnt));

  ring_decode #(.WIDTH(W), .LOCK_CNT(LC), .ERR_W(2)) u_sat (
    .clk(clk), .clr(clr), .ring_in(ring_in), .ring_vld(ring_vld), .err_clr(err_clr),
    .idx(idx2), .idx_vld(idx_vld2), .wrap(wrap2), .locked(locked2),
    .err_pulse(err_pulse2), .err_cnt(err_cnt2));

  always #5 clk = ~clk;

  // Reference model: tracks the hot-bit position of the last one-hot word and
  // the length of the current run of correct rotations.
  int   m_mode;      // 0 searching, 1 confirming, 2 locked
  int   m_prev_pos;
  int   m_run;
  logic [1:0] m_idx;
  logic m_idx_vld, m_wrap, m_locked, m_err;
  logic [7:0] m_cnt;
  logic [1:0] m_cnt2;

  task automatic model_reset();
    m_mode = 0; m_prev_pos = 0; m_run = 0; m_idx = '0;
    m_idx_vld = 0; m_wrap = 0; m_locked = 0; m_err = 0; m_cnt = '0; m_cnt2 = '0;
  endtask

  task automatic model_step(input logic [W-1:0] w, input logic v, input logic ec);
    bit oh;
    int pos;
    bit rot_ok;
    oh = ($countones(w) == 1);
    pos = 0;
    for (int i = 0; i < W; i++) if (w[i]) pos = i;
    rot_ok = oh && (pos == (m_prev_pos + W - 1) % W);
    m_idx_vld = 0; m_wrap = 0; m_err = 0;
    if (v) begin
      if (m_mode == 0) begin
        if (oh) begin m_prev_pos = pos; m_run = 0; m_mode = 1; end
      end else if (m_mode == 1) begin
        if (!oh) m_mode = 0;
        else if (rot_ok) begin
          m_run++; m_prev_pos = pos;
          if (m_run == LC) begin
            m_mode = 2; m_idx = 2'(pos); m_idx_vld = 1; m_wrap = (pos == W-1);
          end
        end else begin m_prev_pos = pos; m_run = 0; end
      end else begin
        if (rot_ok) begin
          m_prev_pos = pos; m_idx = 2'(pos); m_idx_vld = 1; m_wrap = (pos == W-1);
        end else begin m_err = 1; m_mode = 0; end
      end
    end
    m_locked = (m_mode == 2);
    if (ec) begin m_cnt = '0; m_cnt2 = '0; end
    else if (m_err) begin
      if (m_cnt != 8'hFF) m_cnt++;
      if (m_cnt2 != 2'b11) m_cnt2++;
    end
  endtask

  // Drive on the falling edge, let the model see the same sample, settle past the rising edge.
  task automatic step(input logic [W-1:0] w, input logic v, input logic ec);
    @(negedge clk);
    ring_in = w; ring_vld = v; err_clr = ec;
    @(posedge clk);
    model_step(w, v, ec);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr = 1'b0; ring_vld = 1'b0; err_clr = 1'b0; ring_in = '0;
    model_reset();
    #2;
    clr = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if ({locked, idx_vld, wrap, err_pulse, idx, err_cnt, err_cnt2} !== 16'h0) begin
      errors++;
      $display("FAIL reset_state: got lk=%b iv=%b wr=%b ep=%b idx=%0d cnt=%0d cnt2=%0d, want all 0",
               locked, idx_vld, wrap, err_pulse, idx, err_cnt, err_cnt2);
    end
  endtask

  task automatic test_lock_acq();
    logic [W-1:0] seq [5] = '{4'b1000, 4'b0100, 4'b0010, 4'b0001, 4'b1000};
    logic [4:0] exp_lk = 5'b00111, exp_iv = 5'b00111, exp_wr = 5'b00001;
    logic [1:0] exp_idx [5] = '{2'd0, 2'd0, 2'd1, 2'd0, 2'd3};
    for (int i = 0; i < 5; i++) begin
      step(seq[i], 1'b1, 1'b0);
      checks++;
      if (locked !== exp_lk[4-i] || idx_vld !== exp_iv[4-i] || wrap !== exp_wr[4-i] ||
          idx !== exp_idx[i] || err_pulse !== 1'b0) begin
        errors++;
        $display("FAIL lock_acq[%0d]: got lk=%b iv=%b wr=%b idx=%0d ep=%b, want lk=%b iv=%b wr=%b idx=%0d ep=0",
                 i, locked, idx_vld, wrap, idx, err_pulse, exp_lk[4-i], exp_iv[4-i], exp_wr[4-i], exp_idx[i]);
      end
    end
  endtask

  task automatic test_err_locked();
    step(4'b0100, 1'b1, 1'b0);
    checks++;
    if (idx !== 2'd2 || idx_vld !== 1'b1 || locked !== 1'b1) begin
      errors++;
      $display("FAIL err_pre: got idx=%0d iv=%b lk=%b, want 2 1 1", idx, idx_vld, locked);
    end
    step(4'b0100, 1'b1, 1'b0);
    checks++;
    if (err_pulse !== 1'b1 || err_cnt !== 8'd1 || locked !== 1'b0 || idx !== 2'd2 || idx_vld !== 1'b0) begin
      errors++;
      $display("FAIL err_locked: got ep=%b cnt=%0d lk=%b idx=%0d iv=%b, want 1 1 0 2 0",
               err_pulse, err_cnt, locked, idx, idx_vld);
    end
    step(4'b0010, 1'b1, 1'b0);
    checks++;
    if (err_pulse !== 1'b0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL err_one_cycle: got ep=%b lk=%b, want 0 0", err_pulse, locked);
    end
    step(4'b0001, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    checks++;
    if (idx_vld !== 1'b1 || locked !== 1'b1 || idx !== 2'd3 || wrap !== 1'b1) begin
      errors++;
      $display("FAIL err_relock: got iv=%b lk=%b idx=%0d wr=%b, want 1 1 3 1", idx_vld, locked, idx, wrap);
    end
  endtask

  task automatic test_hunt_bad();
    logic [W-1:0] bad [3] = '{4'b0000, 4'b1100, 4'b1111};
    do_reset();
    foreach (bad[i]) begin
      step(bad[i], 1'b1, 1'b0);
      checks++;
      if (locked !== 1'b0 || err_pulse !== 1'b0 || err_cnt !== 8'd0) begin
        errors++;
        $display("FAIL hunt_bad[%0d]: got lk=%b ep=%b cnt=%0d, want 0 0 0", i, locked, err_pulse, err_cnt);
      end
    end
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    checks++;
    if (locked !== 1'b1 || idx !== 2'd3 || wrap !== 1'b1 || idx_vld !== 1'b1) begin
      errors++;
      $display("FAIL hunt_lock: got lk=%b idx=%0d wr=%b iv=%b, want 1 3 1 1", locked, idx, wrap, idx_vld);
    end
  endtask

  task automatic test_gating();
    for (int i = 0; i < 5; i++) begin
      step(W'($urandom), 1'b0, 1'b0);
      checks++;
      if (idx_vld !== 1'b0 || wrap !== 1'b0 || err_pulse !== 1'b0 || locked !== 1'b1 || idx !== 2'd3) begin
        errors++;
        $display("FAIL gating[%0d]: got iv=%b wr=%b ep=%b lk=%b idx=%0d, want 0 0 0 1 3",
                 i, idx_vld, wrap, err_pulse, locked, idx);
      end
    end
    step(4'b0100, 1'b1, 1'b0);
    checks++;
    if (idx_vld !== 1'b1 || idx !== 2'd2) begin
      errors++;
      $display("FAIL gating_resume: got iv=%b idx=%0d, want 1 2", idx_vld, idx);
    end
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    step(4'b0001, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b0);
    step(4'b1000, 1'b1, 1'b1);
    checks++;
    if (err_pulse !== 1'b1 || err_cnt !== 8'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL err_clr_prio: got ep=%b cnt=%0d lk=%b, want 1 0 0", err_pulse, err_cnt, locked);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_sat [5] = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(4'b1000, 1'b1, 1'b0);
      step(4'b0100, 1'b1, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      step(4'b0010, 1'b1, 1'b0);
      checks++;
      if (err_cnt2 !== exp_sat[k] || err_pulse2 !== 1'b1 || err_cnt !== 8'(k+1)) begin
        errors++;
        $display("FAIL saturation[%0d]: got cnt2=%0d ep2=%b cnt=%0d, want %0d 1 %0d",
                 k, err_cnt2, err_pulse2, err_cnt, exp_sat[k], k+1);
      end
    end
  endtask

  task automatic test_async_reset();
    step(4'b1000, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    checks++;
    if (locked !== 1'b1 || err_cnt !== 8'd5) begin
      errors++;
      $display("FAIL async_pre: got lk=%b cnt=%0d, want 1 5", locked, err_cnt);
    end
    #2;
    clr = 1'b0;
    model_reset();
    #1;
    checks++;
    if ({locked, idx_vld, wrap, err_pulse, idx, err_cnt} !== 14'h0) begin
      errors++;
      $display("FAIL async_reset: got lk=%b iv=%b wr=%b ep=%b idx=%0d cnt=%0d, want all 0",
               locked, idx_vld, wrap, err_pulse, idx, err_cnt);
    end
    #1;
    clr = 1'b1;
    step(4'b1000, 1'b1, 1'b0);
    step(4'b0100, 1'b1, 1'b0);
    step(4'b0010, 1'b1, 1'b0);
    checks++;
    if (locked !== 1'b1 || idx !== 2'd1 || idx_vld !== 1'b1) begin
      errors++;
      $display("FAIL async_relock: got lk=%b idx=%0d iv=%b, want 1 1 1", locked, idx, idx_vld);
    end
  endtask

  task automatic test_random();
    int ph = 0;
    logic [W-1:0] w;
    logic v, ec;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 9) < 7) begin
        w = W'(1) << ph;
      end else begin
        w = W'($urandom);
      end
      v = ($urandom_range(0, 9) < 8);
      ec = ($urandom_range(0, 19) == 0);
      if (v) ph = (ph + W - 1) % W;
      step(w, v, ec);
      checks++;
      if ({locked, idx_vld, wrap, err_pulse, idx, err_cnt, err_cnt2} !==
          {m_locked, m_idx_vld, m_wrap, m_err, m_idx, m_cnt, m_cnt2}) begin
        errors++;
        $display("FAIL random[%0d] w=%b v=%b ec=%b: got lk=%b iv=%b wr=%b ep=%b idx=%0d cnt=%0d cnt2=%0d, want lk=%b iv=%b wr=%b ep=%b idx=%0d cnt=%0d cnt2=%0d",
                 n, w, v, ec, locked, idx_vld, wrap, err_pulse, idx, err_cnt, err_cnt2,
                 m_locked, m_idx_vld, m_wrap, m_err, m_idx, m_cnt, m_cnt2);
      end
      checks++;
      if (idx_vld && err_pulse) begin
        errors++;
        $display("FAIL random_exclusive[%0d]: got iv=1 ep=1, want not both", n);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_lock_acq();
    test_err_locked();
    test_hunt_bad();
    test_gating();
    test_saturation();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
